// File: rtl/RV32I_definitions.sv
// Shared RV32I definitions for the five-stage core pipeline.
// Holds the canonical NOP encoding and the IF/ID control FSM state type.
package RV32I_definitions;

  // addi x0, x0, 0
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } pipe_ctrl_state_t;

endpackage : RV32I_definitions

// File: rtl/sat_counter.sv
// Event counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/pipe_ifid_ctrl.sv
// IF/ID pipeline register with stall/flush handling, PC enable, ID/EX bubble
// request, saturating stall/flush event counters and a sticky stall watchdog.
module pipe_ifid_ctrl
  import RV32I_definitions::*;
#(
  parameter int REG_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int STALL_LIMIT    = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [REG_DATA_WIDTH-1:0] IF_PC,
  input  logic [REG_DATA_WIDTH-1:0] IF_Instruction,
  input  logic                      IF_Valid,
  input  logic                      Stall,
  input  logic                      IF_ID_Flush,
  input  logic                      EX_Flush,
  output logic                      PC_En,
  output logic [REG_DATA_WIDTH-1:0] ID_PC,
  output logic [REG_DATA_WIDTH-1:0] ID_Instruction,
  output logic                      ID_Valid,
  output logic                      ID_EX_Bubble,
  output logic [1:0]                Ctrl_State,
  output logic [CNT_WIDTH-1:0]      Stall_Count,
  output logic [CNT_WIDTH-1:0]      Flush_Count,
  output logic                      Stall_Timeout
);

  localparam int RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [REG_DATA_WIDTH-1:0] NOP_WORD = REG_DATA_WIDTH'(RV32I_NOP);

  pipe_ctrl_state_t state;
  logic             stall_taken;
  logic [RUN_W-1:0] run_len;

  // A flush overrides a simultaneous stall, so the stall is only taken alone.
  assign stall_taken  = Stall & ~IF_ID_Flush;
  assign PC_En        = resetn & ~stall_taken;
  assign ID_EX_Bubble = ~resetn | Stall | EX_Flush | (state == FLUSH);
  assign Ctrl_State   = state;

  // Next state depends only on this cycle's requests, so an illegal encoding
  // can never persist past one edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= RUN;
      ID_PC          <= '0;
      ID_Instruction <= NOP_WORD;
      ID_Valid       <= 1'b0;
    end else if (IF_ID_Flush) begin
      state          <= FLUSH;
      ID_PC          <= IF_PC;
      ID_Instruction <= NOP_WORD;
      ID_Valid       <= 1'b0;
    end else if (Stall) begin
      state          <= STALL;
    end else begin
      state          <= RUN;
      ID_PC          <= IF_PC;
      ID_Instruction <= IF_Valid ? IF_Instruction : NOP_WORD;
      ID_Valid       <= IF_Valid;
    end
  end

  // Run length saturates at the limit so a long stall cannot wrap it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_len       <= '0;
      Stall_Timeout <= 1'b0;
    end else if (stall_taken) begin
      if (run_len != RUN_W'(STALL_LIMIT)) run_len <= run_len + 1'b1;
      if (run_len == RUN_W'(STALL_LIMIT - 1)) Stall_Timeout <= 1'b1;
    end else begin
      run_len <= '0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (stall_taken),
    .count  (Stall_Count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (IF_ID_Flush),
    .count  (Flush_Count)
  );

endmodule : pipe_ifid_ctrl

// File: tb/tb_pipe_ifid_ctrl.sv
// Self-checking bench for pipe_ifid_ctrl: per-cycle comparison against a
// behavioural model plus directed literal checks from the test plan.
module tb_pipe_ifid_ctrl;

  localparam int W   = 32;
  localparam int CW  = 4;
  localparam int LIM = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [W-1:0]  if_pc = '0, if_instr = '0;
  logic          if_valid = 1'b0, stall = 1'b0, if_id_flush = 1'b0, ex_flush = 1'b0;
  logic          pc_en, id_valid, id_ex_bubble, stall_timeout;
  logic [W-1:0]  id_pc, id_instr;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_ifid_ctrl #(.REG_DATA_WIDTH(W), .CNT_WIDTH(CW), .STALL_LIMIT(LIM)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .IF_PC          (if_pc),
    .IF_Instruction (if_instr),
    .IF_Valid       (if_valid),
    .Stall          (stall),
    .IF_ID_Flush    (if_id_flush),
    .EX_Flush       (ex_flush),
    .PC_En          (pc_en),
    .ID_PC          (id_pc),
    .ID_Instruction (id_instr),
    .ID_Valid       (id_valid),
    .ID_EX_Bubble   (id_ex_bubble),
    .Ctrl_State     (ctrl_state),
    .Stall_Count    (stall_count),
    .Flush_Count    (flush_count),
    .Stall_Timeout  (stall_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the last edge did, and what IF/ID must now hold.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_timeout;
  int          m_last;          // 0 advanced, 1 stalled, 2 flushed
  int          m_stalls, m_flushes, m_run;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pc = 0; m_instr = NOP; m_valid = 0; m_last = 0;
      m_stalls = 0; m_flushes = 0; m_run = 0; m_timeout = 0;
    end else if (if_id_flush) begin
      m_pc = if_pc; m_instr = NOP; m_valid = 0; m_last = 2;
      m_flushes = (m_flushes + 1 > 15) ? 15 : m_flushes + 1;
      m_run = 0;
    end else if (stall) begin
      m_last = 1;
      m_stalls = (m_stalls + 1 > 15) ? 15 : m_stalls + 1;
      m_run = m_run + 1;
      if (m_run >= LIM) m_timeout = 1;
    end else begin
      m_pc = if_pc; m_instr = if_valid ? if_instr : NOP; m_valid = if_valid;
      m_last = 0; m_run = 0;
    end
  end

  // Single compare process, mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    check("cmp.pc_en",   {31'b0, pc_en},
          {31'b0, resetn && (if_id_flush || !stall)});
    check("cmp.bubble",  {31'b0, id_ex_bubble},
          {31'b0, !resetn || stall || ex_flush || (m_last == 2)});
    check("cmp.id_pc",   id_pc, m_pc);
    check("cmp.id_instr", id_instr, m_instr);
    check("cmp.id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    check("cmp.state",   {30'b0, ctrl_state}, 32'(m_last));
    check("cmp.stall_cnt", {28'b0, stall_count}, 32'(m_stalls));
    check("cmp.flush_cnt", {28'b0, flush_count}, 32'(m_flushes));
    check("cmp.timeout", {31'b0, stall_timeout}, {31'b0, m_timeout});
  end

  // Apply one cycle of inputs shortly after the edge, then sit at mid-cycle.
  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic v,
                      input logic st, input logic ff, input logic ef);
    @(posedge clk); #2;
    if_pc = pc; if_instr = ins; if_valid = v;
    stall = st; if_id_flush = ff; ex_flush = ef;
    @(negedge clk);
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held
    repeat (2) @(negedge clk);
    check("rst.instr", id_instr, 32'h0000_0013);
    check("rst.valid", {31'b0, id_valid}, 32'd0);
    check("rst.pc_en", {31'b0, pc_en}, 32'd0);
    check("rst.bubble", {31'b0, id_ex_bubble}, 32'd1);
    check("rst.cnts", {24'b0, stall_count, flush_count}, 32'd0);
    @(posedge clk); #2 resetn = 1'b1;

    // Straight-line fetch
    step(32'h100, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fetch.pc_en", {31'b0, pc_en}, 32'd1);
    step(32'h104, 32'h00A0_0113, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fetch.id_pc", id_pc, 32'h100);
    check("fetch.id_instr", id_instr, 32'h0050_0093);
    check("fetch.id_valid", {31'b0, id_valid}, 32'd1);

    // Single load-use stall
    step(32'h108, 32'h0020_81B3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("stall.pc_en", {31'b0, pc_en}, 32'd0);
    check("stall.bubble", {31'b0, id_ex_bubble}, 32'd1);
    step(32'h108, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stall.held_pc", id_pc, 32'h104);
    check("stall.held_instr", id_instr, 32'h00A0_0113);
    check("stall.state", {30'b0, ctrl_state}, 32'd1);
    check("stall.count", {28'b0, stall_count}, 32'd1);
    step(32'h10C, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stall.state_run", {30'b0, ctrl_state}, 32'd0);
    check("stall.adv_pc", id_pc, 32'h108);

    // Stall, IF/ID flush and EX flush together
    step(32'h200, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sf.pc_en", {31'b0, pc_en}, 32'd1);
    check("sf.bubble", {31'b0, id_ex_bubble}, 32'd1);
    step(32'h204, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sf.valid", {31'b0, id_valid}, 32'd0);
    check("sf.instr", id_instr, 32'h0000_0013);
    check("sf.pc", id_pc, 32'h200);
    check("sf.flush_cnt", {28'b0, flush_count}, 32'd1);
    check("sf.stall_cnt", {28'b0, stall_count}, 32'd1);
    check("sf.bubble_next", {31'b0, id_ex_bubble}, 32'd1);
    check("sf.state", {30'b0, ctrl_state}, 32'd2);
    step(32'h208, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sf.bubble_clear", {31'b0, id_ex_bubble}, 32'd0);

    // Stall then flush: the held instruction is discarded
    step(32'h20C, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h300, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    check("sthenf.valid", {31'b0, id_valid}, 32'd0);
    check("sthenf.pc", id_pc, 32'h300);

    // Invalid fetch loads a NOP
    step(32'h400, 32'h0030_0193, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("inv.instr", id_instr, 32'h0000_0013);
    check("inv.valid", {31'b0, id_valid}, 32'd0);

    // Watchdog: 7 stalls stay quiet, 8 fire
    for (int i = 0; i < 7; i++) step(32'h500, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    check("wd7.timeout", {31'b0, stall_timeout}, 32'd0);
    for (int i = 0; i < 7; i++) step(32'h500, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("wd8.before", {31'b0, stall_timeout}, 32'd0);
    step(32'h500, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    check("wd8.timeout", {31'b0, stall_timeout}, 32'd1);
    check("wd.stall_sat", {28'b0, stall_count}, 32'd15);
    idle();
    check("wd.sticky", {31'b0, stall_timeout}, 32'd1);

    // Flush counter saturation, then asynchronous reset mid-sequence
    for (int i = 0; i < 20; i++) step(32'h600 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    check("sat.flush", {28'b0, flush_count}, 32'hF);
    step(32'h700, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h704, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 resetn = 1'b0;
    #1;
    check("mrst.flush", {28'b0, flush_count}, 32'd0);
    check("mrst.timeout", {31'b0, stall_timeout}, 32'd0);
    check("mrst.state", {30'b0, ctrl_state}, 32'd0);
    @(negedge clk);
    @(posedge clk); #2 resetn = 1'b1;
    step(32'h800, 32'h0040_0213, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    check("post.pc", id_pc, 32'h800);
    check("post.state", {30'b0, ctrl_state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pipe_ifid_ctrl

// File: doc/pipe_ifid_ctrl.md
# pipe_ifid_ctrl

IF/ID pipeline register with hazard response for the RV32I five-stage core. It consumes the stall and flush requests from the hazard detection unit and turns them into concrete pipeline actions: PC enable, IF/ID hold, NOP injection and an ID/EX bubble request. It sits between the fetch stage and decode, and also keeps stall/flush event counters plus a stall watchdog for debug.

## Interface
Parameters:
- REG_DATA_WIDTH, 32, width of PC and instruction words
- CNT_WIDTH, 16, width of each event counter
- STALL_LIMIT, 8, consecutive stall cycles before the watchdog fires (must be ≥1)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- IF_PC  in  REG_DATA_WIDTH  PC of the instruction currently being fetched
- IF_Instruction  in  REG_DATA_WIDTH  fetched instruction word
- IF_Valid  in  1  fetch output is valid this cycle
- Stall  in  1  load-use stall request
- IF_ID_Flush  in  1  discard the IF/ID contents (taken branch or jump)
- EX_Flush  in  1  discard the ID/EX contents (taken branch)
- PC_En  out  1  fetch PC register may advance
- ID_PC  out  REG_DATA_WIDTH  registered PC presented to decode
- ID_Instruction  out  REG_DATA_WIDTH  registered instruction presented to decode
- ID_Valid  out  1  ID_Instruction is a real instruction
- ID_EX_Bubble  out  1  ID/EX register must load all-zero control this cycle
- Ctrl_State  out  2  current FSM state, for debug
- Stall_Count  out  CNT_WIDTH  number of stall cycles taken
- Flush_Count  out  CNT_WIDTH  number of IF/ID flush events
- Stall_Timeout  out  1  sticky watchdog flag

## Operation
- FSM states: RUN=2'd0, STALL=2'd1, FLUSH=2'd2. Encoding 2'd3 is illegal and returns to RUN.
- Priority each cycle: IF_ID_Flush > Stall > normal advance.
- Flush cycle (IF_ID_Flush=1):
  - IF/ID loads ID_Instruction=NOP (32'h0000_0013), ID_Valid=0, ID_PC=IF_PC.
  - PC_En=1, so the PC loads the redirect target.
  - Next state is FLUSH.
- Stall cycle (Stall=1, no flush):
  - IF/ID holds all fields and PC_En=0.
  - ID_EX_Bubble=1.
  - Next state is STALL.
- Normal advance: IF/ID loads IF_PC and IF_Instruction, with ID_Valid=IF_Valid. PC_En=1.
- ID_EX_Bubble = Stall | EX_Flush | (state==FLUSH). This is combinational.
- FLUSH lasts exactly one cycle, then the block returns to normal handling (RUN, or STALL if Stall is asserted).
- Counters:
  - Stall_Count increments on each cycle in which the stall is actually taken (Stall=1 and IF_ID_Flush=0).
  - Flush_Count increments on each cycle with IF_ID_Flush=1.
  - Both saturate at all-ones; they never wrap.
- Watchdog:
  - An internal run-length counter counts consecutive taken-stall cycles and clears on any non-stall cycle.
  - When it reaches STALL_LIMIT, Stall_Timeout sets and stays set until reset.
- When IF_Valid=0 with no stall or flush, a NOP is loaded with ID_Valid=0.

## Timing
- Reset values: ID_PC=0, ID_Instruction=32'h0000_0013, ID_Valid=0, Ctrl_State=RUN, Stall_Count=0, Flush_Count=0, Stall_Timeout=0, run-length counter=0.
- While resetn=0: PC_En=0 and ID_EX_Bubble=1.
- Reset mid-stall or mid-flush clears all state immediately; operation resumes in RUN on the first edge after deassertion.
- IF/ID latency: one cycle. A fetch presented in cycle N appears on ID_* in cycle N+1.
- PC_En and ID_EX_Bubble are combinational from the inputs and state. There is no registered delay.
- Stall followed by IF_ID_Flush in the next cycle: the flush wins immediately and the held instruction is discarded.
- Stall_Timeout asserts on the edge that ends the STALL_LIMIT-th consecutive stall cycle.

## Structure
- Shared package RV32I_definitions gains:
  - NOP constant `RV32I_NOP` = 32'h0000_0013.
  - typedef enum logic [1:0] pipe_ctrl_state_t {RUN, STALL, FLUSH}.
- One sub-module, `sat_counter` (parameter WIDTH; inputs clk, resetn, inc; output count), instantiated twice for Stall_Count and Flush_Count.
- The watchdog counter stays inline.

## Test plan
- Reset check: hold resetn=0 → ID_Instruction=32'h00000013, ID_Valid=0, PC_En=0, counters=0.
- Straight-line fetch: IF_PC=0x100, IF_Instruction=0x00500093, IF_Valid=1 → one cycle later ID_PC=0x100, ID_Instruction=0x00500093, ID_Valid=1.
- Single load-use stall:
  - Stimulus: Stall=1 for one cycle.
  - Required: PC_En=0, ID_EX_Bubble=1 and ID_* unchanged for that cycle; Stall_Count=1; Ctrl_State goes STALL then RUN.
- Stall and flush together:
  - Stimulus: Stall=1 and IF_ID_Flush=1, EX_Flush=1 in the same cycle.
  - Required: PC_En=1, ID_Valid=0, NOP loaded, Flush_Count=1, Stall_Count unchanged, ID_EX_Bubble=1 this cycle and the next.
- Watchdog: STALL_LIMIT=8 with Stall held for 8 cycles → Stall_Timeout=1 after the 8th edge; it stays 1 after Stall drops. With only 7 cycles, it stays 0.
- Saturation: CNT_WIDTH=4 with 20 flush cycles → Flush_Count=4'hF; reset mid-sequence → Flush_Count=0.
